unified_mem_arbiter: RTL and testbench

Shares the single byte-addressable data memory between the instruction-fetch stage and the MEM-stage load/store unit of the pipelined RISC-V core, so one unified memory serves both. Each cycle it grants at most one requester, drives the memory's read/write strobes, func3 and address, and returns read data one cycle later. Data accesses win by default, with a bounded-wait counter that guarantees fetch progress. Misaligned or illegal-func3 data accesses are rejected with an error instead of reaching memory.

---
 rtl/unified_mem_arbiter.sv | 115 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one byte-addressable data memory between instruction fetch and
// the load/store unit: data wins by default, fetch is forced through after MAX_WAIT denials.
module unified_mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [2:0] FUNC3_LW   = 3'b010;

  logic [7:0] wait_cnt;
  logic       func3_ok;
  logic       align_ok;
  logic       d_legal;
  logic       fetch_win;
  logic       data_win;

  // Legality depends only on the request fields, so it is valid before the grant.
  always_comb begin
    func3_ok = 1'b0;
    case (d_func3)
      3'b000, 3'b001, 3'b010: func3_ok = 1'b1;
      3'b100, 3'b101:         func3_ok = !d_we;
      default:                func3_ok = 1'b0;
    endcase

    align_ok = 1'b1;
    case (d_func3[1:0])
      2'b01:   align_ok = !d_addr[0];
      2'b10:   align_ok = (d_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    d_legal = func3_ok && align_ok;
  end

  always_comb begin
    fetch_win = !rst && if_req && (!d_req || (wait_cnt >= WAIT_LIMIT));
    data_win  = !rst && d_req && !fetch_win;
  end

  assign if_gnt = fetch_win;
  assign d_gnt  = data_win;

  // An illegal data grant consumes the slot but leaves the memory bus idle.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_func3 = 3'b000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (fetch_win) begin
      mem_read  = 1'b1;
      mem_func3 = FUNC3_LW;
      mem_addr  = {if_addr[31:2], 2'b00};
    end else if (data_win && d_legal) begin
      mem_read  = !d_we;
      mem_write = d_we;
      mem_func3 = d_func3;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (if_req && !fetch_win) begin
      if (wait_cnt < WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'h0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= fetch_win;
      if_rdata  <= fetch_win ? mem_rdata : 32'h0;
      d_rvalid  <= data_win;
      d_err     <= data_win && !d_legal;
      d_rdata   <= (data_win && d_legal && !d_we) ? mem_rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a byte-array memory, a per-cycle reference
// model of grants/strobes/responses, and literal checks on hand-computed values.
module tb_unified_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0] mem_bytes [256];

  int total = 0;
  int bad   = 0;

  unified_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_func3   (d_func3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_func3 (mem_func3),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] a0;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[7:0];
    b0 = mem_bytes[a0];
    b1 = mem_bytes[a0 + 8'd1];
    b2 = mem_bytes[a0 + 8'd2];
    b3 = mem_bytes[a0 + 8'd3];
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic logic legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    int   nbytes;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    nbytes = 1 << f3[1:0];
    return ok && ((int'(a[1:0]) % nbytes) == 0);
  endfunction

  // Memory: combinational read, write at the clock edge; junk when not read.
  always_comb begin
    mem_rdata = 32'hA5A5_A5A5;
    if (mem_read) mem_rdata = rd(mem_addr, mem_func3);
  end

  always @(posedge clk) begin
    if (!rst && mem_write) begin
      mem_bytes[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00) mem_bytes[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        mem_bytes[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        mem_bytes[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: streak = consecutive cycles fetch was wanted but refused.
  int          streak = 0;
  logic        e_ifrv = 1'b0;
  logic        e_drv  = 1'b0;
  logic        e_derr = 1'b0;
  logic [31:0] e_ifrd = 32'h0;
  logic [31:0] e_drd  = 32'h0;

  initial begin
    logic fw, dw, lg;
    forever begin
      @(negedge clk);
      chk("if_rvalid", if_rvalid, rst ? 1'b0 : e_ifrv);
      chk("if_rdata",  if_rdata,  rst ? 32'h0 : e_ifrd);
      chk("d_rvalid",  d_rvalid,  rst ? 1'b0 : e_drv);
      chk("d_err",     d_err,     rst ? 1'b0 : e_derr);
      chk("d_rdata",   d_rdata,   rst ? 32'h0 : e_drd);
      chk("rvalid_excl", if_rvalid & d_rvalid, 1'b0);

      if (rst) begin
        fw = 1'b0;
        dw = 1'b0;
        streak = 0;
      end else begin
        fw = if_req && (!d_req || streak >= MAX_WAIT);
        dw = d_req && !fw;
        streak = (if_req && !fw) ? streak + 1 : 0;
      end
      lg = legal(d_we, d_func3, d_addr);

      chk("if_gnt",    if_gnt,    fw);
      chk("d_gnt",     d_gnt,     dw);
      chk("mem_read",  mem_read,  fw || (dw && lg && !d_we));
      chk("mem_write", mem_write, dw && lg && d_we);
      if (fw) begin
        chk("f_mem_addr",  mem_addr,  {if_addr[31:2], 2'b00});
        chk("f_mem_func3", mem_func3, 3'b010);
      end else if (dw && lg) begin
        chk("d_mem_addr",  mem_addr,  d_addr);
        chk("d_mem_func3", mem_func3, d_func3);
        chk("d_mem_wdata", mem_wdata, d_wdata);
      end else if (!dw) begin
        chk("idle_mem_addr",  mem_addr,  32'h0);
        chk("idle_mem_func3", mem_func3, 3'b000);
        chk("idle_mem_wdata", mem_wdata, 32'h0);
      end

      e_ifrv = fw;
      e_ifrd = fw ? rd({if_addr[31:2], 2'b00}, 3'b010) : 32'h0;
      e_drv  = dw;
      e_derr = dw && !lg;
      e_drd  = (dw && lg && !d_we) ? rd(d_addr, d_func3) : 32'h0;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_bytes[i] = 8'(i * 7 + 3);
    mem_bytes[4] = 8'h09;
    mem_bytes[5] = 8'h00;
    mem_bytes[6] = 8'h00;
    mem_bytes[7] = 8'h00;

    rst = 1'b1; if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h20; d_wdata = 32'h0;

    @(negedge clk);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rel_d_gnt", d_gnt, 1'b1);
    chk("rel_if_gnt", if_gnt, 1'b0);
    tick();
    @(negedge clk);
    chk("rel2_d_gnt", d_gnt, 1'b1);
    chk("rel2_d_rvalid", d_rvalid, 1'b1);
    tick(); if_req = 1'b0; d_req = 1'b0;

    tick(); if_req = 1'b1; if_addr = 32'h6;
    @(negedge clk);
    chk("fetch_mem_addr", mem_addr, 32'h4);
    chk("fetch_gnt", if_gnt, 1'b1);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h9);

    tick(); d_req = 1'b1; d_we = 1'b1; d_func3 = 3'b010; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    tick(); d_we = 1'b0; d_func3 = 3'b100; d_addr = 32'h11;
    tick(); d_func3 = 3'b000; d_addr = 32'h13;
    @(negedge clk);
    chk("lbu_rdata", d_rdata, 32'h0000_00BE);
    tick(); d_func3 = 3'b101; d_addr = 32'h12;
    @(negedge clk);
    chk("lb_rdata", d_rdata, 32'hFFFF_FFDE);
    tick(); d_func3 = 3'b001; d_addr = 32'h10;
    @(negedge clk);
    chk("lhu_rdata", d_rdata, 32'h0000_DEAD);
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("lh_rdata", d_rdata, 32'hFFFF_BEEF);

    tick(); if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cont_d_gnt", d_gnt, (i % 5 == 4) ? 1'b0 : 1'b1);
      chk("cont_if_gnt", if_gnt, (i % 5 == 4) ? 1'b1 : 1'b0);
      tick();
    end

    if_req = 1'b0; d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h2;
    @(negedge clk);
    chk("mis_lw_gnt", d_gnt, 1'b1);
    chk("mis_lw_read", mem_read, 1'b0);
    tick(); d_we = 1'b1; d_func3 = 3'b011; d_addr = 32'h10; d_wdata = 32'h1111_1111;
    @(negedge clk);
    chk("mis_lw_err", d_err, 1'b1);
    chk("mis_lw_rdata", d_rdata, 32'h0);
    chk("bad_sb_write", mem_write, 1'b0);
    tick(); d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h10;
    @(negedge clk);
    chk("bad_sb_err", d_err, 1'b1);
    tick(); d_func3 = 3'b110;
    @(negedge clk);
    chk("unchanged_lw", d_rdata, 32'hDEAD_BEEF);
    chk("unchanged_err", d_err, 1'b0);
    tick(); d_func3 = 3'b001; d_addr = 32'h11;
    @(negedge clk);
    chk("bad_load_f3_err", d_err, 1'b1);
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("mis_lh_err", d_err, 1'b1);

    tick(); if_req = 1'b1; if_addr = 32'h8;
    tick(); rst = 1'b1; d_req = 1'b1; d_we = 1'b1; d_func3 = 3'b010; d_addr = 32'h10; d_wdata = 32'h0;
    #1;
    chk("mid_rst_if_rvalid", if_rvalid, 1'b0);
    @(negedge clk);
    chk("rst_store_write", mem_write, 1'b0);
    tick();
    tick(); rst = 1'b0; if_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("post_rst_if_rvalid", if_rvalid, 1'b0);
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("post_rst_lw", d_rdata, 32'hDEAD_BEEF);
    chk("post_rst_if_rvalid2", if_rvalid, 1'b0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
